dm_port_arbiter: RTL and testbench

Sequences and shares the single-port data memory between two requesters: the CPU memory stage (priority requester) and a DMA/bus master. Each requester gets a req/done handshake. The arbiter drives one registered command per access into the DM and returns read data. It raises a stall to the pipeline while a CPU access is outstanding, and a starvation guard keeps the DMA from being locked out.

---
 rtl/dm_arb_pkg.sv | 34 +++
 rtl/dm_arb_pick.sv | 28 ++
 rtl/dm_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ERR  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam logic [1:0] MT_WORD = 2'b00;
  localparam logic [1:0] MT_HALF = 2'b01;
  localparam logic [1:0] MT_BYTE = 2'b10;
  localparam logic [1:0] MT_RSVD = 2'b11;

  // Reserved type, odd halfword, or non-word-aligned word is rejected.
  function automatic logic is_misaligned(input logic [1:0] mtype,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (mtype)
      MT_WORD: bad = |addr_lo;
      MT_HALF: bad = addr_lo[0];
      MT_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational grant selection: CPU has priority unless the DMA has
// been passed over MAX_CPU_BURST times in a row.
module dm_arb_pick #(
  parameter int unsigned MAX_CPU_BURST = 4,
  parameter int unsigned SW            = 3
) (
  input  logic          i_cpu_req,
  input  logic          i_dma_req,
  input  logic [SW-1:0] i_starve_cnt,
  output logic          o_grant_cpu,
  output logic          o_grant_dma
);

  // Pick one requester; DMA is forced once the starvation count saturates.
  always_comb begin
    o_grant_cpu = 1'b0;
    o_grant_dma = 1'b0;
    if (i_cpu_req && i_dma_req) begin
      if (i_starve_cnt == SW'(MAX_CPU_BURST)) o_grant_dma = 1'b1;
      else                                    o_grant_cpu = 1'b1;
    end else if (i_cpu_req) begin
      o_grant_cpu = 1'b1;
    end else if (i_dma_req) begin
      o_grant_dma = 1'b1;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Single-port data-memory arbiter between the CPU memory stage and a DMA
// master. One registered DM command per access, req/done handshakes,
// starvation guard for the DMA.
// Optional stall performance counter: define DM_ARB_PERF_CNT_EN.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 14,
  parameter int unsigned MEM_LAT       = 1,
  parameter int unsigned MAX_CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_type,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [1:0]        dma_type,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_done,
  output logic              dma_err,
  output logic [31:0]       dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       cpu_stall_cycles
);

  localparam int unsigned LW = 3;
  localparam int unsigned SW = (MAX_CPU_BURST < 1) ? 1 : $clog2(MAX_CPU_BURST + 1);

  state_t              r_state, w_state_nxt;
  owner_t              r_owner;
  logic [LW-1:0]       r_lat;
  logic [SW-1:0]       r_starve;
  logic                r_mem_en, r_mem_we;
  logic [1:0]          r_mem_type;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_acc_we;
  logic [31:0]         r_cpu_rdata, r_dma_rdata;

  logic                w_grant_cpu, w_grant_dma, w_any_grant;
  logic                w_sel_we, w_sel_bad, w_issue, w_fin, w_load_fin;
  logic [1:0]          w_sel_type;
  logic [31:0]         w_sel_addr, w_sel_wdata;
  logic                w_unused;

  dm_arb_pick #(
    .MAX_CPU_BURST(MAX_CPU_BURST),
    .SW           (SW)
  ) u_pick (
    .i_cpu_req   (cpu_req),
    .i_dma_req   (dma_req),
    .i_starve_cnt(r_starve),
    .o_grant_cpu (w_grant_cpu),
    .o_grant_dma (w_grant_dma)
  );

  // Request mux, validity check, next state and completion decode.
  always_comb begin
    w_any_grant = w_grant_cpu | w_grant_dma;
    w_sel_we    = w_grant_dma ? dma_we    : cpu_we;
    w_sel_type  = w_grant_dma ? dma_type  : cpu_type;
    w_sel_addr  = w_grant_dma ? dma_addr  : cpu_addr;
    w_sel_wdata = w_grant_dma ? dma_wdata : cpu_wdata;
    w_sel_bad   = is_misaligned(w_sel_type, w_sel_addr[1:0]);
    w_issue     = (r_state == IDLE) && w_any_grant && !w_sel_bad;
    w_fin       = (r_state == ACC) && (r_lat == '0);
    w_load_fin  = w_fin && !r_acc_we;
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_grant) w_state_nxt = w_sel_bad ? ERR : ACC;
      ACC:     if (r_lat == '0) w_state_nxt = IDLE;
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Registered DM command, owner, latency and starvation counters, read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= OWN_CPU;
      r_lat       <= '0;
      r_starve    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_type  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_acc_we    <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_mem_en <= w_issue;
      r_mem_we <= w_issue & w_sel_we;
      if (w_issue) begin
        r_mem_type  <= w_sel_type;
        r_mem_addr  <= w_sel_addr[ADDR_W-1:0];
        r_mem_wdata <= w_sel_wdata;
        r_acc_we    <= w_sel_we;
        r_lat       <= LW'(MEM_LAT);
      end else if (r_state == ACC && r_lat != '0) begin
        r_lat <= r_lat - LW'(1);
      end
      if (r_state == IDLE && w_any_grant)
        r_owner <= w_grant_dma ? OWN_DMA : OWN_CPU;
      if (r_state == IDLE) begin
        if (w_grant_dma || !dma_req)
          r_starve <= '0;
        else if (w_grant_cpu && r_starve != SW'(MAX_CPU_BURST))
          r_starve <= r_starve + SW'(1);
      end
      if (w_load_fin) begin
        if (r_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
        else                    r_dma_rdata <= mem_rdata;
      end
    end
  end

  // Done/err are decoded from state so read data can be forwarded in the
  // same cycle it is valid on mem_rdata; the registers hold it afterwards.
  always_comb begin
    cpu_done  = (w_fin || r_state == ERR) && (r_owner == OWN_CPU);
    dma_done  = (w_fin || r_state == ERR) && (r_owner == OWN_DMA);
    cpu_err   = (r_state == ERR) && (r_owner == OWN_CPU);
    dma_err   = (r_state == ERR) && (r_owner == OWN_DMA);
    cpu_rdata = (w_load_fin && r_owner == OWN_CPU) ? mem_rdata : r_cpu_rdata;
    dma_rdata = (w_load_fin && r_owner == OWN_DMA) ? mem_rdata : r_dma_rdata;
    cpu_stall = cpu_req & ~cpu_done;
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_type  = r_mem_type;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  assign w_unused = ^{cpu_addr[31:ADDR_W], dma_addr[31:ADDR_W]};

`ifdef DM_ARB_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count every cycle the pipeline is held by an outstanding CPU access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_stall_cnt <= '0;
    else if (cpu_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign cpu_stall_cycles = r_stall_cnt;
`else
  assign cpu_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: instance A (MEM_LAT=1) and instance B
// (MEM_LAT=3) share all inputs; each scenario checks one of them.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [1:0]  cpu_type = 0, dma_type = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [31:0] mem_rdata = 0;

  logic        a_cpu_done, a_cpu_err, a_cpu_stall, a_dma_done, a_dma_err;
  logic [31:0] a_cpu_rdata, a_dma_rdata, a_mem_wdata, a_perf;
  logic        a_mem_en, a_mem_we;
  logic [1:0]  a_mem_type;
  logic [13:0] a_mem_addr;

  logic        b_cpu_done, b_cpu_err, b_cpu_stall, b_dma_done, b_dma_err;
  logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_wdata, b_perf;
  logic        b_mem_en, b_mem_we;
  logic [1:0]  b_mem_type;
  logic [13:0] b_mem_addr;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(14), .MEM_LAT(1), .MAX_CPU_BURST(4)) u_a (
    .clk(clk), .reset(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_type(cpu_type), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_done(a_cpu_done), .cpu_err(a_cpu_err),
    .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_type(dma_type), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_done(a_dma_done), .dma_err(a_dma_err),
    .dma_rdata(a_dma_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_type(a_mem_type),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata),
    .cpu_stall_cycles(a_perf)
  );

  dm_port_arbiter #(.ADDR_W(14), .MEM_LAT(3), .MAX_CPU_BURST(4)) u_b (
    .clk(clk), .reset(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_type(cpu_type), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_done(b_cpu_done), .cpu_err(b_cpu_err),
    .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_type(dma_type), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_done(b_dma_done), .dma_err(b_dma_err),
    .dma_rdata(b_dma_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_type(b_mem_type),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
    .cpu_stall_cycles(b_perf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] order [10];
    logic [1:0] exp_order [10];
    int ng;
    int npulse;
    int perf_exp;

    // Reset state
    tick(); tick();
    chk("rst_mem_en",   {31'd0, a_mem_en},   32'd0);
    chk("rst_mem_we",   {31'd0, a_mem_we},   32'd0);
    chk("rst_mem_addr", {18'd0, a_mem_addr}, 32'd0);
    chk("rst_wdata",    a_mem_wdata,         32'd0);
    chk("rst_done",     {30'd0, a_cpu_done, a_dma_done}, 32'd0);
    chk("rst_perf",     a_perf,              32'd0);
    rst = 1'b0;
    tick();

    // CPU load, address masking, MEM_LAT=1
    mem_rdata = 32'hDEADBEEF;
    cpu_req = 1; cpu_we = 0; cpu_type = 2'b00; cpu_addr = 32'h0000_4010;
    #1 chk("ld_stall_t", {31'd0, a_cpu_stall}, 32'd1);
    tick();
    chk("ld_mem_en",   {31'd0, a_mem_en},   32'd1);
    chk("ld_mem_addr", {18'd0, a_mem_addr}, 32'h10);
    chk("ld_mem_we",   {31'd0, a_mem_we},   32'd0);
    chk("ld_stall_t1", {31'd0, a_cpu_stall}, 32'd1);
    chk("ld_done_t1",  {31'd0, a_cpu_done}, 32'd0);
    tick();
    chk("ld_done",   {31'd0, a_cpu_done},  32'd1);
    chk("ld_rdata",  a_cpu_rdata,          32'hDEADBEEF);
    chk("ld_stall_done", {31'd0, a_cpu_stall}, 32'd0);
    chk("ld_mem_en_off", {31'd0, a_mem_en}, 32'd0);
    cpu_req = 0;
    tick();
    chk("ld_done_pulse", {31'd0, a_cpu_done}, 32'd0);
    chk("ld_rdata_hold", a_cpu_rdata, 32'hDEADBEEF);

    // CPU misaligned half store -> error path
    cpu_req = 1; cpu_we = 1; cpu_type = 2'b01; cpu_addr = 32'h3; cpu_wdata = 32'h55;
    tick();
    chk("err_done",   {31'd0, a_cpu_done}, 32'd1);
    chk("err_err",    {31'd0, a_cpu_err},  32'd1);
    chk("err_mem_en", {31'd0, a_mem_en},   32'd0);
    chk("err_mem_we", {31'd0, a_mem_we},   32'd0);
    chk("err_rdata_hold", a_cpu_rdata, 32'hDEADBEEF);
    cpu_req = 0;
    tick();
    chk("err_done_off", {30'd0, a_cpu_done, a_cpu_err}, 32'd0);
    chk("err_mem_en2",  {31'd0, a_mem_en}, 32'd0);

    // DMA word store
    dma_req = 1; dma_we = 1; dma_type = 2'b00; dma_addr = 32'h8; dma_wdata = 32'h12345678;
    tick();
    chk("dst_mem_en",   {31'd0, a_mem_en},   32'd1);
    chk("dst_mem_we",   {31'd0, a_mem_we},   32'd1);
    chk("dst_mem_addr", {18'd0, a_mem_addr}, 32'h8);
    chk("dst_wdata",    a_mem_wdata,         32'h12345678);
    chk("dst_done_t1",  {31'd0, a_dma_done}, 32'd0);
    tick();
    chk("dst_done",     {31'd0, a_dma_done}, 32'd1);
    chk("dst_err",      {31'd0, a_dma_err},  32'd0);
    chk("dst_cpu_done", {31'd0, a_cpu_done}, 32'd0);
    chk("dst_single",   {31'd0, a_mem_en},   32'd0);
    dma_req = 0;
    tick();

    // Both held: starvation guard ordering
    exp_order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    for (int i = 0; i < 10; i++) order[i] = 2'd3;
    cpu_req = 1; cpu_we = 0; cpu_type = 2'b00; cpu_addr = 32'h100;
    dma_req = 1; dma_we = 0; dma_type = 2'b00; dma_addr = 32'h200;
    ng = 0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      tick();
      if (a_mem_en) begin
        order[ng] = (a_mem_addr == 14'h200) ? 2'd1 : 2'd0;
        ng++;
      end
    end
    cpu_req = 0; dma_req = 0;
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++)
      chk($sformatf("grant_order[%0d]", i), {30'd0, order[i]}, {30'd0, exp_order[i]});

    // Reset mid-access on MEM_LAT=3 instance
    rst = 1; tick(); tick(); rst = 0; tick();
    mem_rdata = 32'hCAFEF00D;
    cpu_req = 1; cpu_we = 0; cpu_type = 2'b00; cpu_addr = 32'h20;
    tick();
    chk("rma_mem_en", {31'd0, b_mem_en}, 32'd1);
    tick();
    chk("rma_in_acc", {31'd0, b_cpu_done}, 32'd0);
    #2 rst = 1;
    #1;
    chk("rma_mem_en_rst",   {31'd0, b_mem_en},   32'd0);
    chk("rma_mem_addr_rst", {18'd0, b_mem_addr}, 32'd0);
    chk("rma_done_rst",     {31'd0, b_cpu_done}, 32'd0);
    chk("rma_rdata_rst",    b_cpu_rdata,         32'd0);
    chk("rma_perf_rst",     b_perf,              32'd0);
    cpu_req = 0;
    tick(); tick();
    rst = 0;
    npulse = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (b_cpu_done || b_mem_en) npulse++;
    end
    chk("rma_no_done", npulse, 32'd0);
    cpu_req = 1;
    #1 chk("rma2_stall", {31'd0, b_cpu_stall}, 32'd1);
    tick();
    chk("rma2_mem_en", {31'd0, b_mem_en}, 32'd1);
    chk("rma2_addr",   {18'd0, b_mem_addr}, 32'h20);
    tick();
    chk("rma2_t2", {31'd0, b_cpu_done}, 32'd0);
    tick();
    chk("rma2_t3", {31'd0, b_cpu_done}, 32'd0);
    tick();
    chk("rma2_done",  {31'd0, b_cpu_done}, 32'd1);
    chk("rma2_rdata", b_cpu_rdata, 32'hCAFEF00D);
    cpu_req = 0;
    tick();

    // Stall counter: four stall cycles at MEM_LAT=3
`ifdef DM_ARB_PERF_CNT_EN
    perf_exp = 4;
`else
    perf_exp = 0;
`endif
    chk("perf_b", b_perf, perf_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
